// File: rtl/idct_transpose_buf.sv
// ============================================================================
// Module   : idct_transpose_buf
// Purpose  : Rounds/narrows IDCT first-pass results into ping-pong 4x4 banks,
//            written by rows and read out by columns for the second pass.
// Option   : IDCT_TRANSPOSE_SAT_EN -- clamp to 16-bit range instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idct_transpose_buf #(
  parameter int SHIFT = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [23:0]        in_data,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_1,
  output logic signed [15:0] out_2,
  output logic signed [15:0] out_3,
  output logic signed [15:0] out_4
);

  localparam logic signed [24:0] c_HALF    = 25'sd1 <<< (SHIFT - 1);
  localparam logic signed [24:0] c_SAT_MAX = 25'sd32767;
  localparam logic signed [24:0] c_SAT_MIN = -25'sd32768;

  logic [15:0]        r_mem [2][16];
  logic [1:0]         r_full;
  logic               r_wr_bank;
  logic               r_rd_bank;
  logic [3:0]         r_wr_idx;
  logic [1:0]         r_rd_col;

  logic signed [24:0] w_sum;
  logic signed [24:0] w_shift;
  logic [15:0]        w_y;
  logic               w_wr_en;
  logic               w_rd_en;
  logic               w_wr_last;
  logic               w_rd_last;
  logic [1:0]         w_set;
  logic [1:0]         w_clr;

  // 25-bit intermediate keeps the rounding add from overflowing near full scale
  assign w_sum   = $signed({in_data[23], in_data}) + c_HALF;
  assign w_shift = w_sum >>> SHIFT;

`ifdef IDCT_TRANSPOSE_SAT_EN
  always_comb begin
    if (w_shift > c_SAT_MAX) begin
      w_y = 16'h7FFF;
    end else if (w_shift < c_SAT_MIN) begin
      w_y = 16'h8000;
    end else begin
      w_y = w_shift[15:0];
    end
  end
`else
  logic w_unused;
  assign w_unused = ^w_shift[24:16];
  assign w_y      = w_shift[15:0];
`endif

  assign in_ready  = ~r_full[r_wr_bank];
  assign out_valid = r_full[r_rd_bank];

  assign w_wr_en   = in_valid & in_ready;
  assign w_rd_en   = out_valid & out_ready;
  assign w_wr_last = w_wr_en & (r_wr_idx == 4'd15);
  assign w_rd_last = w_rd_en & (r_rd_col == 2'd3);

  // Writer and reader always target different banks, so set/clear never collide
  assign w_set = w_wr_last ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr = w_rd_last ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_idx  <= 4'd0;
      r_rd_col  <= 2'd0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 16; i++) begin
          r_mem[b][i] <= 16'h0000;
        end
      end
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;
      if (w_wr_en) begin
        r_mem[r_wr_bank][r_wr_idx] <= w_y;
        r_wr_idx                   <= r_wr_idx + 4'd1;
        if (w_wr_last) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end
      if (w_rd_en) begin
        r_rd_col <= r_rd_col + 2'd1;
        if (w_rd_last) begin
          r_rd_bank <= ~r_rd_bank;
        end
      end
    end
  end

  // Row n of the read bank at the current column: sample index is row*4 + col
  assign out_1 = r_mem[r_rd_bank][{2'd0, r_rd_col}];
  assign out_2 = r_mem[r_rd_bank][{2'd1, r_rd_col}];
  assign out_3 = r_mem[r_rd_bank][{2'd2, r_rd_col}];
  assign out_4 = r_mem[r_rd_bank][{2'd3, r_rd_col}];

endmodule

`default_nettype wire

// File: doc/idct_transpose_buf.md
IDCT_TRANSPOSE_BUF -- requirements
Module: idct_transpose_buf

Interface
REQ-001 Parameter: SHIFT, 7, right-shift applied to each accumulated 24-bit IDCT first-pass result.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  in_data holds a valid first-pass result.
REQ-005 Port: in_data  input  24  signed two's-complement accumulated result from the upstream multiply-accumulate chain.
REQ-006 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-007 Port: out_valid  output  1  out_1..out_4 hold a valid transposed column.
REQ-008 Port: out_ready  input  1  downstream second-pass stage consumes the column this cycle.
REQ-009 Port: out_1, out_2, out_3, out_4  output  16 each  signed column elements for rows 0..3, fed to the second-pass stage inputs 1..4.

Function
REQ-010 Input accepted only when in_valid=1 and in_ready=1 at a rising clk edge.
REQ-011 Conversion: y = (in_data + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, 25-bit intermediate (no overflow before shift).
REQ-012 y narrowed to 16 bits per Configuration (saturate or wrap).
REQ-013 Storage: two 4x4 banks of 16-bit words (ping-pong), per-bank full flag.
REQ-014 Write pointer wr_idx 0..15 within write bank wr_bank; accepted sample k stored at row k/4, column k%4.
REQ-015 On acceptance with wr_idx=15: full[wr_bank] set, wr_idx wraps to 0, wr_bank toggles, same edge.
REQ-016 in_ready = NOT full[wr_bank]; both banks full -> in_ready=0.
REQ-017 out_valid = full[rd_bank]; out_n = bank[rd_bank][row n-1][rd_col] (transpose: rows written, columns read).
REQ-018 out_valid rises on the same edge that accepts the 16th sample of a block (visible the following cycle; latency 1 cycle from last write).
REQ-019 Column transfer when out_valid=1 and out_ready=1; rd_col increments 0..3.
REQ-020 Transfer with rd_col=3: full[rd_bank] cleared, rd_col wraps to 0, rd_bank toggles, same edge.
REQ-021 While out_valid=1 and out_ready=0, out_1..out_4 and out_valid held stable.
REQ-022 Write to one bank and read of the other in the same cycle both proceed; a bank freed on an edge accepts writes from the next cycle.
REQ-023 Sustained throughput: 1 sample/cycle in with out_ready=1 continuously, in_ready never deasserts.

Reset
REQ-024 reset=0 asynchronously clears wr_idx, rd_col, wr_bank, rd_bank, both full flags and all storage to 0.
REQ-025 During/after reset: in_ready=1, out_valid=0, out_1..out_4=0.
REQ-026 Reset mid-block discards any partially written or partially read block; next accepted sample is sample 0 of bank 0.

Configuration
REQ-027 Macro IDCT_TRANSPOSE_SAT_EN defined: y clamped to [-32768, 32767].
REQ-028 Macro not defined: y truncated to its low 16 bits (wrap), no clamping logic instantiated.

Verification
REQ-029 Rounding: in_data = 64, 63, -64, -65 (SHIFT=7) -> stored 1, 0, 0, -1.
REQ-030 Overflow: in_data=24'h7FFFFF -> 16'h7FFF with IDCT_TRANSPOSE_SAT_EN, 16'h0000 without; in_data=24'h800000 -> 16'h8000 with, 16'h0000 without.
REQ-031 Transpose: write in_data = k*128, k=0..15, out_ready=1 -> columns (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15) on 4 consecutive cycles.
REQ-032 Backpressure: out_ready=0, in_valid=1 for 40 cycles -> exactly 32 samples accepted, in_ready=0 from cycle after 32nd, out_valid=1 with column (0,4,8,12) of first block held stable.
REQ-033 Reset mid-block: 7 samples written, reset pulsed low -> in_ready=1, out_valid=0, outputs 0; next 16 samples form a complete fresh block read out correctly.
REQ-034 Streaming: 64 consecutive samples, out_ready=1 -> in_ready stays 1, 16 columns delivered in order, no loss or duplication.
